seq_decoder: RTL and testbench
==============================

SEQ_DECODER -- requirements
Module: seq_decoder

Interface
REQ-001 The block SHALL have parameter IN_W, default 2, giving the select width; the output width N = 2**IN_W; legal range 1..6.
REQ-002 The block SHALL have parameter HOLD, default 4, giving the cycles each one-hot output stays asserted; legal range 1..255.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-005 The block SHALL have port in  input  IN_W  select code, sampled on accept.
REQ-006 The block SHALL have port valid  input  1  request strobe.
REQ-007 The block SHALL have port ready  output  1  high when a request can be accepted.
REQ-008 The block SHALL have port y  output  N  registered one-hot decode, all-zero when idle.
REQ-009 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 The block SHALL have port done  output  1  single-cycle pulse on completion of a hold or scan.
REQ-011 The block SHALL have port scan  input  1  scan-mode request; present only when DEC_SCAN_EN is defined.

Function
REQ-012 The FSM SHALL have states IDLE, HOLD and SCAN; SCAN exists only with DEC_SCAN_EN.
REQ-013 ready SHALL be combinational: (state==IDLE) and not scan; scan is treated as 0 when the macro is absent.
REQ-014 Accept SHALL occur on an edge with valid and ready both high; the next cycle y = 1<<in, state = HOLD and the hold counter = HOLD-1.
REQ-015 In HOLD, y SHALL be held constant and the counter decremented each cycle, so y is nonzero for exactly HOLD cycles.
REQ-016 In HOLD with counter==0, the next edge SHALL clear y to 0, pulse done high for one cycle and return to IDLE.
REQ-017 valid while busy SHALL be ignored (ready=0); in and valid changes during HOLD SHALL not affect y.
REQ-018 The minimum spacing between accepted requests SHALL be HOLD+1 cycles; a valid held high from completion is accepted on the first IDLE cycle.
REQ-019 done SHALL be registered, asserted in the first IDLE cycle after completion, and coincide with y==0.
REQ-020 The hold counter SHALL be 8 bits wide; no arithmetic wrap occurs within the legal HOLD range.
REQ-021 y SHALL never have more than one bit set on any cycle.

Reset
REQ-022 An edge with rst_n low SHALL set state=IDLE, y=0, done=0 and counter=0, overriding all other inputs.
REQ-023 Reset mid-HOLD or mid-SCAN SHALL abort with no done pulse; ready SHALL be 1 on the first cycle after release if scan=0.
REQ-024 The first valid accept SHALL be possible on the first edge with rst_n high.

Configuration
REQ-025 Macro DEC_SCAN_EN SHALL enable scan mode; when undefined, the scan port and SCAN state are omitted and behaviour is REQ-012..021 only.
REQ-026 With DEC_SCAN_EN, scan=1 in IDLE SHALL take priority over valid; the next cycle y=1 (bit 0), state=SCAN and counter=HOLD-1.
REQ-027 In SCAN, each bit k SHALL be held HOLD cycles, then y shifts left one place; after bit N-1 completes, y=0, done pulses and the FSM returns to IDLE.
REQ-028 A full scan SHALL last N*HOLD cycles of nonzero y; deasserting scan mid-walk SHALL not abort it; scan still high at completion restarts a new walk after one IDLE cycle.

Verification (IN_W=2, HOLD=4)
REQ-029 The bench SHALL cover reset-then-idle: rst_n low 2 cycles then high -> y=0000, ready=1, busy=0, done=0.
REQ-030 The bench SHALL cover single accept: in=2, valid=1 for 1 cycle -> y=0100 for exactly 4 cycles, then y=0000 with done=1 for 1 cycle.
REQ-031 The bench SHALL cover back-to-back: valid held high with in=3 then in=1 -> y=1000 ×4, one idle cycle with done=1, then y=0010 ×4; intermediate in changes ignored.
REQ-032 The bench SHALL cover reset mid-hold: accept in=1, assert rst_n low on the 2nd hold cycle -> y=0000 next edge, no done, ready=1 after release.
REQ-033 The bench SHALL cover scan (DEC_SCAN_EN): scan=1 for 1 cycle with valid=1 in=3 -> y=0001,0010,0100,1000 each ×4 (16 cycles), then done=1; the valid is not accepted.
REQ-034 The bench SHALL cover the one-hot check across all scenarios: $countones(y)<=1 on every cycle.

Source files
------------

// File: rtl/seq_decoder.sv
// seq_decoder: registered one-hot decoder that holds each accepted code for HOLD cycles.
// Define DEC_SCAN_EN to add the scan input, which walks a single bit across y.
module seq_decoder #(
  parameter int unsigned IN_W = 2,
  parameter int unsigned HOLD = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IN_W-1:0]     in,
  input  logic                valid,
`ifdef DEC_SCAN_EN
  input  logic                scan,
`endif
  output logic                ready,
  output logic [2**IN_W-1:0]  y,
  output logic                busy,
  output logic                done
);

  localparam int unsigned N     = 2**IN_W;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD
`ifdef DEC_SCAN_EN
    , ST_SCAN
`endif
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [N-1:0]     r_y;
  logic [N-1:0]     w_y_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_scan;
  logic [N-1:0]     w_dec;

`ifdef DEC_SCAN_EN
  assign w_scan = scan;
`else
  assign w_scan = 1'b0;
`endif

  assign w_dec = N'(1) << in;
  assign ready = (r_state == ST_IDLE) && !w_scan;
  assign busy  = (r_state != ST_IDLE);
  assign y     = r_y;
  assign done  = r_done;

  // State, counter and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_y     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_y     <= w_y_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_y_nxt     = r_y;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_y_nxt = '0;
`ifdef DEC_SCAN_EN
        if (w_scan) begin
          w_state_nxt = ST_SCAN;
          w_y_nxt     = N'(1);
          w_cnt_nxt   = CNT_LOAD;
        end else
`endif
        if (valid && ready) begin
          w_state_nxt = ST_HOLD;
          w_y_nxt     = w_dec;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_y_nxt     = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
`ifdef DEC_SCAN_EN
      // Walk ends once the top bit has served its full hold.
      ST_SCAN: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (r_y[N-1]) begin
          w_state_nxt = ST_IDLE;
          w_y_nxt     = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_y_nxt   = r_y << 1;
          w_cnt_nxt = CNT_LOAD;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_y_nxt     = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_decoder.sv
// tb_seq_decoder: directed vector table, scan walk and random traffic for seq_decoder,
// checked against a queue-of-future-outputs reference model.
module tb_seq_decoder;

  localparam int unsigned IN_W = 2;
  localparam int unsigned HOLD = 4;
  localparam int unsigned N    = 2**IN_W;

  logic            clk;
  logic            rst_n;
  logic [IN_W-1:0] in;
  logic            valid;
  logic            scan;
  logic            ready;
  logic [N-1:0]    y;
  logic            busy;
  logic            done;

  int n_cmp;
  int n_fail;

  seq_decoder #(.IN_W(IN_W), .HOLD(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .valid (valid),
`ifdef DEC_SCAN_EN
    .scan  (scan),
`endif
    .ready (ready),
    .y     (y),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: each accepted request enqueues the exact y/done values of the
  // cycles it will occupy; an empty queue means the block is idle.
  typedef struct {
    logic [N-1:0] y;
    logic         d;
  } ent_t;

  ent_t         q[$];
  ent_t         e;
  logic [N-1:0] m_y;
  logic         m_d;

  task automatic model_step();
    if (!rst_n) begin
      q.delete();
      m_y = '0;
      m_d = 1'b0;
    end else begin
      if (q.size() == 0) begin
        if (scan) begin
          for (int k = 0; k < int'(N); k++)
            for (int h = 0; h < int'(HOLD); h++)
              q.push_back('{y: N'(1) << k, d: 1'b0});
          q.push_back('{y: '0, d: 1'b1});
        end else if (valid) begin
          for (int h = 0; h < int'(HOLD); h++)
            q.push_back('{y: N'(1) << in, d: 1'b0});
          q.push_back('{y: '0, d: 1'b1});
        end
      end
      if (q.size() != 0) begin
        e   = q.pop_front();
        m_y = e.y;
        m_d = e.d;
      end else begin
        m_y = '0;
        m_d = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and compare every output with the model.
  task automatic cycle(input logic r, input logic v, input logic [IN_W-1:0] i, input logic s);
    @(negedge clk);
    rst_n = r;
    valid = v;
    in    = i;
    scan  = s;
    @(posedge clk);
    model_step();
    #1;
    chk("model_y", 32'(y), 32'(m_y));
    chk("model_done", 32'(done), 32'(m_d));
    chk("model_busy", 32'(busy), 32'(q.size() != 0));
    chk("model_ready", 32'(ready), 32'((q.size() == 0) && !scan));
    chk("onehot", 32'($countones(y) <= 1), 32'd1);
  endtask

  typedef struct {
    logic            r;
    logic            v;
    logic [IN_W-1:0] i;
    logic [N-1:0]    ey;
    logic            ed;
    logic            er;
    logic            eb;
  } vec_t;

  vec_t tv[30];
  logic s_r;
  logic s_v;
  logic s_s;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    valid  = 1'b0;
    in     = '0;
    scan   = 1'b0;
    m_y    = '0;
    m_d    = 1'b0;

    //          rst   valid in     y         done  ready busy
    tv[0]  = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tv[1]  = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tv[3]  = '{1'b1, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b0, 1'b1};
    tv[4]  = '{1'b1, 1'b0, 2'd0, 4'b0100, 1'b0, 1'b0, 1'b1};
    tv[5]  = '{1'b1, 1'b0, 2'd3, 4'b0100, 1'b0, 1'b0, 1'b1};
    tv[6]  = '{1'b1, 1'b0, 2'd1, 4'b0100, 1'b0, 1'b0, 1'b1};
    tv[7]  = '{1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b1, 1'b0};
    tv[8]  = '{1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tv[9]  = '{1'b1, 1'b1, 2'd3, 4'b1000, 1'b0, 1'b0, 1'b1};
    tv[10] = '{1'b1, 1'b1, 2'd1, 4'b1000, 1'b0, 1'b0, 1'b1};
    tv[11] = '{1'b1, 1'b1, 2'd0, 4'b1000, 1'b0, 1'b0, 1'b1};
    tv[12] = '{1'b1, 1'b1, 2'd1, 4'b1000, 1'b0, 1'b0, 1'b1};
    tv[13] = '{1'b1, 1'b1, 2'd1, 4'b0000, 1'b1, 1'b1, 1'b0};
    tv[14] = '{1'b1, 1'b1, 2'd1, 4'b0010, 1'b0, 1'b0, 1'b1};
    tv[15] = '{1'b1, 1'b0, 2'd2, 4'b0010, 1'b0, 1'b0, 1'b1};
    tv[16] = '{1'b1, 1'b1, 2'd3, 4'b0010, 1'b0, 1'b0, 1'b1};
    tv[17] = '{1'b1, 1'b0, 2'd0, 4'b0010, 1'b0, 1'b0, 1'b1};
    tv[18] = '{1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b1, 1'b0};
    tv[19] = '{1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tv[20] = '{1'b1, 1'b1, 2'd1, 4'b0010, 1'b0, 1'b0, 1'b1};
    tv[21] = '{1'b1, 1'b0, 2'd0, 4'b0010, 1'b0, 1'b0, 1'b1};
    tv[22] = '{1'b0, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b1, 1'b0};
    tv[23] = '{1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tv[24] = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tv[25] = '{1'b1, 1'b1, 2'd0, 4'b0001, 1'b0, 1'b0, 1'b1};
    tv[26] = '{1'b1, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b0, 1'b1};
    tv[27] = '{1'b1, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b0, 1'b1};
    tv[28] = '{1'b1, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b0, 1'b1};
    tv[29] = '{1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b1, 1'b0};

    for (int k = 0; k < 30; k++) begin
      cycle(tv[k].r, tv[k].v, tv[k].i, 1'b0);
      chk($sformatf("tv%0d_y", k), 32'(y), 32'(tv[k].ey));
      chk($sformatf("tv%0d_done", k), 32'(done), 32'(tv[k].ed));
      chk($sformatf("tv%0d_ready", k), 32'(ready), 32'(tv[k].er));
      chk($sformatf("tv%0d_busy", k), 32'(busy), 32'(tv[k].eb));
    end

    // Long hold with in/valid toggling every cycle: y must stay frozen.
    cycle(1'b1, 1'b0, 2'd0, 1'b0);
    cycle(1'b1, 1'b1, 2'd3, 1'b0);
    for (int h = 1; h < int'(HOLD); h++) begin
      cycle(1'b1, 1'(h % 2), 2'(h), 1'b0);
      chk("hold_frozen", 32'(y), 32'h8);
    end
    cycle(1'b1, 1'b0, 2'd0, 1'b0);
    chk("hold_end_done", 32'(done), 32'd1);

`ifdef DEC_SCAN_EN
    // Scan pulse with a competing valid: a full walk, and the valid is dropped.
    cycle(1'b1, 1'b0, 2'd0, 1'b0);
    cycle(1'b1, 1'b1, 2'd3, 1'b1);
    chk("scan_start", 32'(y), 32'h1);
    for (int c = 1; c < int'(N * HOLD); c++) begin
      cycle(1'b1, 1'b0, 2'd0, 1'b0);
      chk($sformatf("scan_c%0d", c), 32'(y), 32'(N'(1) << (c / int'(HOLD))));
    end
    cycle(1'b1, 1'b0, 2'd0, 1'b0);
    chk("scan_done_y", 32'(y), 32'd0);
    chk("scan_done", 32'(done), 32'd1);
    cycle(1'b1, 1'b0, 2'd0, 1'b0);
    chk("scan_no_accept", 32'(y), 32'd0);
    chk("scan_idle_busy", 32'(busy), 32'd0);
`endif

    // Random traffic, including occasional resets and scan requests.
    for (int c = 0; c < 3000; c++) begin
      s_r = ($urandom_range(0, 59) != 0);
      s_v = ($urandom_range(0, 2) == 0);
`ifdef DEC_SCAN_EN
      s_s = ($urandom_range(0, 24) == 0);
`else
      s_s = 1'b0;
`endif
      cycle(s_r, s_v, IN_W'($urandom), s_s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
